mem_responder: RTL
==================

# mem_responder

Memory-side responder for the CPU's level-held memory protocol: it answers `mem_read`/`mem_write` requests with a single-cycle `mem_resp` pulse after a programmable latency. It is backed by a byte-enabled word array. It sits opposite the multicycle control/datapath as the simulation and bring-up memory, and is the reference end of the protocol for later cache work.

## Interface
- `DEPTH_LOG2`, default 10: log2 of the number of 32-bit words in the array.
- `LATENCY`, default 3: cycles from request acceptance to `mem_resp`. Legal range is 1..15.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `mem_read` in 1: read request, held by the initiator until `mem_resp`.
- `mem_write` in 1: write request, held by the initiator until `mem_resp`.
- `mem_address` in 32: byte address. Bits [1:0] are ignored.
- `mem_wdata` in 32: write data.
- `mem_byte_enable` in 4: write byte lanes. Bit i enables `mem_wdata[8i+7:8i]`.
- `mem_resp` out 1: one-cycle completion pulse.
- `mem_rdata` out 32: read data, valid only while `mem_resp`=1 for a read.

## Operation
- FSM states are IDLE, BUSY and RESP.
- IDLE:
  - If `mem_read`|`mem_write`, latch the address word index `mem_address[DEPTH_LOG2+1:2]`, `mem_wdata`, `mem_byte_enable`, and an op bit.
  - Load `cnt` with `LATENCY-1`.
  - Go to RESP if `cnt` loads 0, else go to BUSY.
- BUSY: decrement `cnt`. Go to RESP when `cnt` reaches 0.
- RESP:
  - `mem_resp`=1 for exactly this cycle.
  - Read: `mem_rdata` = array[latched index], the full word; the byte enable is ignored for reads.
  - Write: on the edge ending RESP, write the enabled lanes of the latched data. Disabled lanes are unchanged.
  - Always return to IDLE.
- Address aliasing: upper address bits above `DEPTH_LOG2+1` are ignored, so addresses wrap modulo the array size.
- Inputs are sampled only at acceptance. Later changes to address, data, mask or request level before `mem_resp` are ignored.
- Request dropped mid-transaction (protocol violation): the transaction still completes and `mem_resp` still pulses.
- `mem_read` and `mem_write` both high at acceptance: treated as a write, and `mem_rdata` stays 0.
- Protocol rule: the initiator deasserts its request in the cycle after `mem_resp`. A request still high in IDLE after RESP is accepted as a new transaction; no dead cycle is inserted.
- `mem_rdata` is 0 in every cycle other than a read RESP.

## Timing
- Request first high in cycle c means `mem_resp` is high in cycle c+`LATENCY` (c+`LATENCY`+extra with stall enabled).
- For a write, array contents are visible to a read accepted in cycle c+`LATENCY`+1 or later.
- Minimum turnaround is one transaction every `LATENCY`+1 cycles.
- Reset values: `mem_resp`=0, `mem_rdata`=0, state=IDLE, `cnt`=0, latches=0.
- Array contents are not reset.
- Reset mid-transaction: the transaction is aborted, no `mem_resp` is issued, and a pending write is not performed.

## Configuration
- `MEM_RESPONDER_STALL_EN` defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; reset value 8'hA5) advances once per accepted request.
  - `lfsr[1:0]` at acceptance adds 0..3 extra BUSY cycles, for a total latency of `LATENCY`..`LATENCY`+3.
  - The counter widens accordingly.
- Undefined: latency is exactly `LATENCY`, and no LFSR logic is present.

## Test plan
- Write to 0x0000_0010 with `mem_wdata`=0xDEADBEEF and mask 4'b1111, then read 0x10. Required: `mem_resp` at c+3 for each, and `mem_rdata`=0xDEADBEEF.
- Partial writes:
  - Preload 0x11223344 at 0x20.
  - Write 0xAABBCCDD with mask 4'b0101.
  - Read 0x20. Required: 0x11BB33DD.
- Wrap-around: with `DEPTH_LOG2`=10, write 0x5 to 0x0000_1004, then read 0x0000_0004. Required: 0x5.
- Mid-transaction changes:
  - Issue a read of 0x20.
  - At cycle c+1 drop `mem_read` and change the address to 0x40.
  - Required: `mem_resp` still at c+3, returning the 0x20 contents.
- Reset during write:
  - Pulse `rst_n` low in BUSY of a write of 0x77 to 0x30.
  - Required: `mem_resp`=0 and `mem_rdata`=0 immediately after reset.
  - A later read of 0x30 returns the old value.
- Back-to-back and simultaneous requests, with `LATENCY`=1:
  - Hold `mem_read` continuously. Required: `mem_resp` toggles 0,1,0,1...
  - Assert read+write together. Required: a write occurs and `mem_rdata` stays 0.

Source files
------------

// File: rtl/mem_if.sv
// Level-held memory request/response bundle between the CPU
// and a memory-side responder.
interface mem_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic        mem_resp;
  logic [31:0] mem_rdata;

  modport master (
    output mem_read,
    output mem_write,
    output mem_address,
    output mem_wdata,
    output mem_byte_enable,
    input  mem_resp,
    input  mem_rdata
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_address,
    input  mem_wdata,
    input  mem_byte_enable,
    output mem_resp,
    output mem_rdata
  );
endinterface

// File: rtl/mem_responder.sv
// Byte-enabled word memory answering mem_if requests after LATENCY cycles.
// Define MEM_RESPONDER_STALL_EN to add 0..3 LFSR-driven extra stall cycles.
module mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 3
) (
  input logic clk,
  input logic rst_n,
  mem_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

`ifdef MEM_RESPONDER_STALL_EN
  localparam int CW = 5;
`else
  localparam int CW = 4;
`endif

  state_t state_q;
  state_t state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] load;

  logic [DEPTH_LOG2-1:0] idx_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        wr_q;

  logic req;
  logic accept;
  logic [31:0] mem [2**DEPTH_LOG2];

  assign req    = bus.mem_read | bus.mem_write;
  assign accept = (state_q == IDLE) && req;

`ifdef MEM_RESPONDER_STALL_EN
  logic [7:0] lfsr_q;
  logic fb;

  assign fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 8'hA5;
    end else if (accept) begin
      lfsr_q <= {lfsr_q[6:0], fb};
    end
  end

  assign load = CW'(LATENCY - 1) + CW'(lfsr_q[1:0]);
`else
  assign load = CW'(LATENCY - 1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d   = load;
          state_d = (load == '0) ? RESP : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Both request lines high is resolved as a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
    end else if (accept) begin
      idx_q   <= bus.mem_address[DEPTH_LOG2+1:2];
      wdata_q <= bus.mem_wdata;
      be_q    <= bus.mem_byte_enable;
      wr_q    <= bus.mem_write;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == RESP && wr_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign bus.mem_resp  = (state_q == RESP);
  assign bus.mem_rdata = (state_q == RESP && !wr_q) ? mem[idx_q] : '0;

  logic unused_addr;
  assign unused_addr = ^{bus.mem_address[31:DEPTH_LOG2+2],
                         bus.mem_address[1:0]};

endmodule
